debug_loader: RTL and testbench

DEBUG_LOADER -- requirements
Module: debug_loader

---
 rtl/debug_pkg.sv | 26 ++
 rtl/debug_loader_word_assembler.sv | 55 +++++
 rtl/debug_loader.sv | 186 ++++++++++++++++++
 tb/tb_debug_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared codes and encodings for the debug loader
// Contents: command bytes, response bytes, run-mode encoding, parser states.
package debug_pkg;

    localparam logic [7:0] CMD_LOAD      = 8'h07;
    localparam logic [7:0] CMD_CONT      = 8'h08;
    localparam logic [7:0] CMD_STEP_MODE = 8'h09;
    localparam logic [7:0] CMD_STEP      = 8'h0A;
    localparam logic [7:0] CMD_HALT      = 8'h0B;

    localparam logic [7:0] RESP_ACK = 8'hAA;
    localparam logic [7:0] RESP_NAK = 8'hEE;

    localparam logic [1:0] MODE_HALT = 2'd0;
    localparam logic [1:0] MODE_CONT = 2'd1;
    localparam logic [1:0] MODE_STEP = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_CNT  = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_LOAD_CHK  = 3'd3,
        ST_SEND      = 3'd4
    } loader_state_t;

endpackage

// File: rtl/debug_loader_word_assembler.sv
// rtl/debug_loader_word_assembler.sv - little-endian byte-to-word assembler
// Module word_assembler, parameter WORD_BYTES.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clear           restart assembly at byte 0 of a new word
//   i_byte_valid      i_byte is a data byte to absorb this cycle
//   i_byte            data byte
//   o_last            combinational: this byte completes a word
//   o_next_word       combinational: word including this byte (full when o_last)
module word_assembler #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clear,
    input  logic                    i_byte_valid,
    input  logic [7:0]              i_byte,
    output logic                    o_last,
    output logic [8*WORD_BYTES-1:0] o_next_word
);
    localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [CNT_W-1:0] byte_cnt;

    assign o_last = i_byte_valid && (byte_cnt == CNT_W'(WORD_BYTES - 1));

    // Each new byte enters at the top and older bytes move down, so after
    // WORD_BYTES bytes the first one received sits in [7:0].
    generate
        if (WORD_BYTES == 1) begin : g_single
            assign o_next_word = i_byte;
        end else begin : g_multi
            logic [8*(WORD_BYTES-1)-1:0] hold;

            assign o_next_word = {i_byte, hold};

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    hold <= '0;
                end else if (i_byte_valid) begin
                    hold <= o_next_word[8*WORD_BYTES-1:8];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            byte_cnt <= '0;
        end else if (i_byte_valid) begin
            byte_cnt <= o_last ? '0 : byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/debug_loader.sv
// rtl/debug_loader.sv - UART-driven instruction loader and CPU run control
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum byte after data).
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_rx_data, i_rx_valid  received UART byte and its one-cycle strobe
//   i_tx_busy              UART transmitter busy
//   o_tx_data, o_tx_start  response byte and one-cycle transmit request
//   o_imem_we              instruction-memory write strobe
//   o_imem_addr            byte address of the written word
//   o_imem_data            assembled little-endian word
//   o_stall                CPU pipeline freeze
//   o_step                 one-cycle single-step pulse
//   o_mode                 run mode: 0 HALT, 1 CONT, 2 STEP
module debug_loader
    import debug_pkg::*;
#(
    parameter int WORD_BYTES      = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_INSTRUCTION = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    input  logic                    i_tx_busy,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_start,
    output logic                    o_imem_we,
    output logic [ADDR_WIDTH-1:0]   o_imem_addr,
    output logic [8*WORD_BYTES-1:0] o_imem_data,
    output logic                    o_stall,
    output logic                    o_step,
    output logic [1:0]              o_mode
);
    loader_state_t state;
    logic [7:0]    word_cnt;
    logic [7:0]    word_total;
    logic          resp_ok;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    checksum;
`endif

    logic                    asm_clear;
    logic                    asm_valid;
    logic                    asm_last;
    logic [8*WORD_BYTES-1:0] asm_word;

    // The count byte starts a fresh word so a stale partial word can never leak in.
    assign asm_clear = (state == ST_LOAD_CNT) && i_rx_valid;
    assign asm_valid = (state == ST_LOAD_DATA) && i_rx_valid;

    word_assembler #(
        .WORD_BYTES (WORD_BYTES)
    ) u_word_assembler (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (asm_clear),
        .i_byte_valid (asm_valid),
        .i_byte       (i_rx_data),
        .o_last       (asm_last),
        .o_next_word  (asm_word)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            o_mode      <= MODE_HALT;
            o_stall     <= 1'b1;
            o_step      <= 1'b0;
            o_imem_we   <= 1'b0;
            o_tx_start  <= 1'b0;
            o_tx_data   <= 8'h00;
            o_imem_addr <= '0;
            o_imem_data <= '0;
            word_cnt    <= 8'd0;
            word_total  <= 8'd0;
            resp_ok     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            checksum    <= 8'h00;
`endif
        end else begin
            o_step     <= 1'b0;
            o_tx_start <= 1'b0;
            o_imem_we  <= 1'b0;
            // Stall follows the mode unless a branch below overrides it; this
            // also re-asserts stall the cycle after a single step.
            o_stall    <= (o_mode != MODE_CONT);

            case (state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                state   <= ST_LOAD_CNT;
                                o_mode  <= MODE_HALT;
                                o_stall <= 1'b1;
                            end
                            CMD_CONT: begin
                                o_mode  <= MODE_CONT;
                                o_stall <= 1'b0;
                            end
                            CMD_STEP_MODE: begin
                                o_mode  <= MODE_STEP;
                                o_stall <= 1'b1;
                            end
                            CMD_HALT: begin
                                o_mode  <= MODE_HALT;
                                o_stall <= 1'b1;
                            end
                            CMD_STEP: begin
                                if (o_mode == MODE_STEP) begin
                                    o_step  <= 1'b1;
                                    o_stall <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_LOAD_CNT: begin
                    if (i_rx_valid) begin
                        word_total <= i_rx_data;
                        word_cnt   <= 8'd0;
                        resp_ok    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        checksum   <= 8'h00;
`endif
                        state      <= (i_rx_data == 8'd0) ? ST_SEND : ST_LOAD_DATA;
                    end
                end

                ST_LOAD_DATA: begin
                    if (i_rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
                        checksum <= checksum ^ i_rx_data;
`endif
                        if (asm_last) begin
                            // Out-of-range words are swallowed and spoil the response.
                            if (int'(word_cnt) < MAX_INSTRUCTION) begin
                                o_imem_we   <= 1'b1;
                                o_imem_addr <= ADDR_WIDTH'(word_cnt) * ADDR_WIDTH'(WORD_BYTES);
                                o_imem_data <= asm_word;
                            end else begin
                                resp_ok <= 1'b0;
                            end
                            word_cnt <= word_cnt + 8'd1;
                            if (word_cnt == word_total - 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= ST_LOAD_CHK;
`else
                                state <= ST_SEND;
`endif
                            end
                        end
                    end
                end

                ST_LOAD_CHK: begin
`ifdef LOADER_CHECKSUM_EN
                    if (i_rx_valid) begin
                        if (i_rx_data != checksum) begin
                            resp_ok <= 1'b0;
                        end
                        state <= ST_SEND;
                    end
`else
                    state <= ST_IDLE;
`endif
                end

                ST_SEND: begin
                    // Incoming bytes are ignored here by design.
                    if (!i_tx_busy) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= resp_ok ? RESP_ACK : RESP_NAK;
                        state      <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_loader.sv
// tb/tb_debug_loader.sv - scoreboard bench for debug_loader
module tb_debug_loader;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        step;
    logic [1:0]  mode;

    int checks = 0;
    int errors = 0;
    int tx_count = 0;
    int step_count = 0;
    bit step_watch = 1'b0;
    logic prev_step = 1'b0;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];

    always #5 clk = ~clk;

    debug_loader #(
        .WORD_BYTES      (4),
        .ADDR_WIDTH      (32),
        .MAX_INSTRUCTION (2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_tx_busy   (tx_busy),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_imem_we   (imem_we),
        .o_imem_addr (imem_addr),
        .o_imem_data (imem_data),
        .o_stall     (stall),
        .o_step      (step),
        .o_mode      (mode)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or transmits.
    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", {imem_addr, imem_data}, 64'h0);
                if (imem_addr == 32'h0 && imem_data == 32'h0) begin
                    errors++;
                    $display("FAIL unexpected_write actual=1 expected=0");
                end
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("write_addr", imem_addr, w.addr);
                check("write_data", imem_data, w.data);
            end
        end
        if (tx_start) begin
            tx_count++;
            if (exp_tx.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_tx actual=%0h expected=none", tx_data);
            end else begin
                check("tx_byte", tx_data, exp_tx.pop_front());
            end
        end
        if (step) begin
            step_count++;
            if (prev_step) begin
                errors++;
                $display("FAIL step_width actual=2 expected=1");
            end
        end
        prev_step = step;
        if (step_watch) check("stall_vs_step", stall, !step);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Back-to-back bytes, one per cycle, so a byte lands in each write cycle.
    task automatic send_burst(input byte_q_t bytes);
        @(negedge clk);
        foreach (bytes[i]) begin
            rx_data  = bytes[i];
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] xor_all(input byte_q_t d);
        logic [7:0] x = 8'h00;
        foreach (d[i]) x = x ^ d[i];
        return x;
    endfunction

    task automatic load(input logic [7:0] n, input byte_q_t data, input logic [7:0] csum);
        byte_q_t b;
        b.push_back(8'h07);
        b.push_back(n);
        foreach (data[i]) b.push_back(data[i]);
`ifdef LOADER_CHECKSUM_EN
        b.push_back(csum);
`else
        if (csum == 8'h00) b = b;
`endif
        send_burst(b);
    endtask

    task automatic wait_drain(input string name);
        int left;
        left = exp_wr.size() + exp_tx.size();
        for (int i = 0; i < 300 && left != 0; i++) begin
            @(negedge clk);
            left = exp_wr.size() + exp_tx.size();
        end
        check(name, left, 0);
    endtask

    initial begin
        byte_q_t d;
        int      t0;
        int      s0;

        repeat (3) @(negedge clk);
        check("rst_mode", mode, 2'd0);
        check("rst_stall", stall, 1'b1);
        check("rst_step", step, 1'b0);
        check("rst_we", imem_we, 1'b0);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_data", imem_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Two-word load with transmitter busy: response must wait for it.
        tx_busy = 1'b1;
        d = '{8'h03, 8'h00, 8'h01, 8'h3C, 8'h01, 8'h00, 8'h02, 8'h3C};
        exp_wr.push_back('{32'h0, 32'h3C010003});
        exp_wr.push_back('{32'h4, 32'h3C020001});
        exp_tx.push_back(8'hAA);
        t0 = tx_count;
        load(8'd2, d, xor_all(d));
        check("load_stall", stall, 1'b1);
        repeat (10) @(negedge clk);
        check("tx_held_while_busy", tx_count - t0, 0);
        tx_busy = 1'b0;
        wait_drain("drain_load2");
        check("load2_tx_count", tx_count - t0, 1);

        // CONT then HALT.
        send_byte(8'h08);
        check("cont_mode", mode, 2'd1);
        check("cont_stall", stall, 1'b0);
        repeat (5) @(negedge clk);
        check("cont_stall_hold", stall, 1'b0);
        send_byte(8'h0B);
        check("halt_mode", mode, 2'd0);
        check("halt_stall", stall, 1'b1);

        // STEP in HALT mode is ignored.
        s0 = step_count;
        send_byte(8'h0A);
        repeat (3) @(negedge clk);
        check("step_in_halt", step_count - s0, 0);

        // Step mode with three single steps.
        send_byte(8'h09);
        check("stepmode_mode", mode, 2'd2);
        check("stepmode_stall", stall, 1'b1);
        step_watch = 1'b1;
        s0 = step_count;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h0A);
            repeat (2) @(negedge clk);
        end
        step_watch = 1'b0;
        check("step_pulses", step_count - s0, 3);
        send_byte(8'h0B);
        check("halt2_mode", mode, 2'd0);

        // Overflow past MAX_INSTRUCTION=2.
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
              8'h99, 8'hAA, 8'hBB, 8'hCC};
        exp_wr.push_back('{32'h0, 32'h44332211});
        exp_wr.push_back('{32'h4, 32'h88776655});
        exp_tx.push_back(8'hEE);
        load(8'd3, d, xor_all(d));
        wait_drain("drain_overflow");

        // Zero-length load goes straight to ACK.
        exp_tx.push_back(8'hAA);
        t0 = tx_count;
        send_burst('{8'h07, 8'h00});
        wait_drain("drain_n0");
        check("n0_tx_count", tx_count - t0, 1);

        // Reset after 5 data bytes abandons the load.
        exp_wr.push_back('{32'h0, 32'h04030201});
        t0 = tx_count;
        send_burst('{8'h07, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("reset_no_tx", tx_count - t0, 0);
        check("reset_writes_left", exp_wr.size(), 0);
        check("reset_mode", mode, 2'd0);
        check("reset_stall", stall, 1'b1);

        // Fresh load after reset; command bytes are plain data here.
        d = '{8'h07, 8'h0A, 8'h0B, 8'h08};
        exp_wr.push_back('{32'h0, 32'h080B0A07});
        exp_tx.push_back(8'hAA);
        load(8'd1, d, xor_all(d));
        wait_drain("drain_cmd_data");
        check("cmd_data_mode", mode, 2'd0);

`ifdef LOADER_CHECKSUM_EN
        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_wr.push_back('{32'h0, 32'h04030201});
        exp_tx.push_back(8'hEE);
        load(8'd1, d, 8'h05);
        wait_drain("drain_bad_csum");
        exp_wr.push_back('{32'h0, 32'h04030201});
        exp_tx.push_back(8'hAA);
        load(8'd1, d, 8'h04);
        wait_drain("drain_good_csum");
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
